// File: rtl/cvu_token_pkg.sv
// cvu_token_pkg: shared widths, token layout and collector FSM states for the CVU token collector
package cvu_token_pkg;
  localparam int TID_W = 10;
  localparam int BB_W = 5;
  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [BB_W-1:0] bb_primary;
    logic [BB_W-1:0] bb_alt;
  } token_entry_t;
  typedef enum logic [1:0] {RUN, DRAIN, FORCE, DONE} collector_state_t;
endpackage

// File: rtl/token_fifo_2w1r.sv
// token_fifo_2w1r: DEPTH-entry FIFO with two ordered write ports (port 0 lands first), one read port and an occupancy count
module token_fifo_2w1r #(
  parameter int DEPTH = 16,
  parameter int W = 20,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0_i,
  input  logic [W-1:0]  wd0_i,
  input  logic          we1_i,
  input  logic [W-1:0]  wd1_i,
  input  logic          re_i,
  output logic [W-1:0]  rd_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q, wp1;
  logic [CW-1:0] cnt_q;
  assign wp1 = wp_q + AW'(1);
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wp_q] <= wd0_i;
    if (we1_i) mem_q[we0_i ? wp1 : wp_q] <= wd1_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(we0_i) + AW'(we1_i);
      rp_q <= rp_q + AW'(re_i);
      cnt_q <= cnt_q + CW'(we0_i) + CW'(we1_i) - CW'(re_i);
    end
  end
  assign rd_o = mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/cvu_token_collector.sv
// cvu_token_collector: turns two lanes of branch results into {tid, primary BB, alternate BB} tokens, issues one per cycle, drains and pulses force_w at kernel end; CVU_TOKEN_STATS_EN adds tok_issued/hold_stall counters
module cvu_token_collector #(
  parameter int DEPTH = 16,
  parameter int TID_W = cvu_token_pkg::TID_W,
  parameter int BB_W = cvu_token_pkg::BB_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l0_valid,
  input  logic [TID_W-1:0] l0_tid,
  input  logic             l0_taken,
  input  logic [BB_W-1:0]  l0_bb_taken,
  input  logic [BB_W-1:0]  l0_bb_fall,
  output logic             l0_ready,
  input  logic             l1_valid,
  input  logic [TID_W-1:0] l1_tid,
  input  logic             l1_taken,
  input  logic [BB_W-1:0]  l1_bb_taken,
  input  logic [BB_W-1:0]  l1_bb_fall,
  output logic             l1_ready,
  input  logic             hold,
  input  logic             drain_req,
  output logic             token_valid,
  output logic [TID_W-1:0] token_buffer,
  output logic [BB_W-1:0]  BB_target_1,
  output logic [BB_W-1:0]  BB_target_2,
  output logic             force_w,
  output logic             drain_done,
  output logic [CW-1:0]    fifo_count
`ifdef CVU_TOKEN_STATS_EN
  ,
  output logic [15:0]      tok_issued,
  output logic [15:0]      hold_stall
`endif
);
  import cvu_token_pkg::*;
  localparam int EW = TID_W + 2 * BB_W;
  collector_state_t state_q, state_d;
  logic [CW-1:0] count;
  logic [EW-1:0] wd0, wd1, head;
  logic push0, push1, pop;
  logic tv_q;
  logic [TID_W-1:0] tid_q;
  logic [BB_W-1:0] bb1_q, bb2_q;
  assign l0_ready = count <= CW'(DEPTH - 1) && state_q != DONE;
  assign l1_ready = count <= CW'(DEPTH - 2) && state_q != DONE;
  assign push0 = l0_valid && l0_ready;
  assign push1 = l1_valid && l1_ready;
  assign pop = !hold && count != '0;
  assign wd0 = l0_taken ? {l0_tid, l0_bb_taken, l0_bb_fall} : {l0_tid, l0_bb_fall, l0_bb_taken};
  assign wd1 = l1_taken ? {l1_tid, l1_bb_taken, l1_bb_fall} : {l1_tid, l1_bb_fall, l1_bb_taken};
  token_fifo_2w1r #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .we0_i(push0),
    .wd0_i(wd0),
    .we1_i(push1),
    .wd1_i(wd1),
    .re_i(pop),
    .rd_o(head),
    .count_o(count)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (drain_req) state_d = DRAIN;
      DRAIN: if (count == '0 && !hold && !push0 && !push1) state_d = FORCE;
      FORCE: state_d = DONE;
      DONE:  if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tv_q <= 1'b0;
      tid_q <= '0;
      bb1_q <= '0;
      bb2_q <= '0;
    end else begin
      state_q <= state_d;
      tv_q <= pop;
      if (pop) {tid_q, bb1_q, bb2_q} <= head;
    end
  end
  assign token_valid = tv_q;
  assign token_buffer = tid_q;
  assign BB_target_1 = bb1_q;
  assign BB_target_2 = bb2_q;
  assign force_w = state_q == FORCE;
  assign drain_done = state_q == DONE;
  assign fifo_count = count;
`ifdef CVU_TOKEN_STATS_EN
  logic [15:0] issued_q, stall_q;
  logic clr;
  assign clr = state_q == DONE && !drain_req;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      issued_q <= '0;
      stall_q <= '0;
    end else begin
      issued_q <= (pop && issued_q != '1) ? issued_q + 16'd1 : issued_q;
      stall_q <= (hold && count != '0 && stall_q != '1) ? stall_q + 16'd1 : stall_q;
    end
  end
  assign tok_issued = issued_q;
  assign hold_stall = stall_q;
`endif
endmodule

// File: tb/tb_cvu_token_collector.sv
// tb_cvu_token_collector: directed self-checking bench for cvu_token_collector
module tb_cvu_token_collector;
  logic clk = 1'b0;
  logic rst;
  logic l0_valid, l0_taken, l1_valid, l1_taken, hold, drain_req;
  logic [9:0] l0_tid, l1_tid, token_buffer;
  logic [4:0] l0_bb_taken, l0_bb_fall, l1_bb_taken, l1_bb_fall, BB_target_1, BB_target_2;
  logic l0_ready, l1_ready, token_valid, force_w, drain_done;
  logic [4:0] fifo_count;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cvu_token_collector dut (
    .clk(clk),
    .rst(rst),
    .l0_valid(l0_valid),
    .l0_tid(l0_tid),
    .l0_taken(l0_taken),
    .l0_bb_taken(l0_bb_taken),
    .l0_bb_fall(l0_bb_fall),
    .l0_ready(l0_ready),
    .l1_valid(l1_valid),
    .l1_tid(l1_tid),
    .l1_taken(l1_taken),
    .l1_bb_taken(l1_bb_taken),
    .l1_bb_fall(l1_bb_fall),
    .l1_ready(l1_ready),
    .hold(hold),
    .drain_req(drain_req),
    .token_valid(token_valid),
    .token_buffer(token_buffer),
    .BB_target_1(BB_target_1),
    .BB_target_2(BB_target_2),
    .force_w(force_w),
    .drain_done(drain_done),
    .fifo_count(fifo_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic lane0(input logic v, input logic [9:0] t, input logic tk, input logic [4:0] bt, input logic [4:0] bf);
    l0_valid = v;
    l0_tid = t;
    l0_taken = tk;
    l0_bb_taken = bt;
    l0_bb_fall = bf;
  endtask
  task automatic lane1(input logic v, input logic [9:0] t, input logic tk, input logic [4:0] bt, input logic [4:0] bf);
    l1_valid = v;
    l1_tid = t;
    l1_taken = tk;
    l1_bb_taken = bt;
    l1_bb_fall = bf;
  endtask
  task automatic tok(input string tag, input logic [9:0] t, input logic [4:0] b1, input logic [4:0] b2);
    chk({tag, "_valid"}, token_valid, 1);
    chk({tag, "_tid"}, token_buffer, t);
    chk({tag, "_bb1"}, BB_target_1, b1);
    chk({tag, "_bb2"}, BB_target_2, b2);
  endtask
  initial begin
    rst = 1'b1;
    hold = 1'b0;
    drain_req = 1'b0;
    lane0(0, 0, 0, 0, 0);
    lane1(0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_tv", token_valid, 0);
    chk("rst_tid", token_buffer, 0);
    chk("rst_bb1", BB_target_1, 0);
    chk("rst_bb2", BB_target_2, 0);
    chk("rst_force", force_w, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    step();
    chk("run_l0_ready", l0_ready, 1);
    chk("run_l1_ready", l1_ready, 1);
    lane0(1, 10'h041, 1, 7, 3);
    step();
    lane0(0, 0, 0, 0, 0);
    chk("single_count1", fifo_count, 1);
    chk("single_early", token_valid, 0);
    step();
    tok("single", 10'h041, 7, 3);
    chk("single_count0", fifo_count, 0);
    step();
    chk("single_idle", token_valid, 0);
    chk("single_hold_data", token_buffer, 10'h041);
    lane0(1, 5, 0, 9, 2);
    lane1(1, 6, 1, 4, 12);
    step();
    lane0(0, 0, 0, 0, 0);
    lane1(0, 0, 0, 0, 0);
    chk("dual_count2", fifo_count, 2);
    chk("dual_early", token_valid, 0);
    step();
    tok("dual_a", 5, 2, 9);
    chk("dual_count1", fifo_count, 1);
    step();
    tok("dual_b", 6, 4, 12);
    chk("dual_count0", fifo_count, 0);
    step();
    chk("dual_idle", token_valid, 0);
    hold = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lane0(1, 10'(100 + 2 * i), 1, 1, 2);
      lane1(1, 10'(101 + 2 * i), 1, 1, 2);
      step();
    end
    chk("fill_count14", fifo_count, 14);
    lane0(1, 114, 1, 1, 2);
    lane1(0, 0, 0, 0, 0);
    step();
    chk("fill_count15", fifo_count, 15);
    chk("fill15_l0_ready", l0_ready, 1);
    chk("fill15_l1_ready", l1_ready, 0);
    lane0(1, 115, 1, 1, 2);
    lane1(1, 116, 1, 1, 2);
    step();
    lane1(0, 0, 0, 0, 0);
    chk("fill_count16", fifo_count, 16);
    chk("full_l0_ready", l0_ready, 0);
    chk("full_l1_ready", l1_ready, 0);
    chk("full_hold_tv", token_valid, 0);
    hold = 1'b0;
    lane0(1, 200, 1, 1, 2);
    step();
    lane0(0, 0, 0, 0, 0);
    chk("full_pop_count", fifo_count, 15);
    tok("full_pop", 100, 1, 2);
    step();
    tok("full_next", 101, 1, 2);
    for (int i = 0; i < 14; i++) step();
    chk("full_last_tid", token_buffer, 115);
    chk("full_empty", fifo_count, 0);
    step();
    chk("full_idle", token_valid, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lane0(1, 10'(16 + i), i[0], 5'(i), 5'(20 + i));
      step();
    end
    lane0(0, 0, 0, 0, 0);
    chk("hold_count3", fifo_count, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_tv", token_valid, 0);
    end
    hold = 1'b0;
    step();
    tok("hold_a", 16, 20, 0);
    step();
    tok("hold_b", 17, 1, 21);
    step();
    tok("hold_c", 18, 22, 2);
    step();
    chk("hold_idle", token_valid, 0);
    hold = 1'b1;
    lane0(1, 10'h020, 1, 3, 4);
    lane1(1, 10'h021, 0, 3, 4);
    step();
    lane0(0, 0, 0, 0, 0);
    lane1(0, 0, 0, 0, 0);
    chk("drain_count2", fifo_count, 2);
    hold = 1'b0;
    drain_req = 1'b1;
    step();
    tok("drain_a", 10'h020, 3, 4);
    chk("drain_a_force", force_w, 0);
    step();
    tok("drain_b", 10'h021, 4, 3);
    chk("drain_b_force", force_w, 0);
    step();
    chk("drain_force", force_w, 1);
    chk("drain_force_done", drain_done, 0);
    chk("drain_force_tv", token_valid, 0);
    step();
    chk("drain_force_pulse", force_w, 0);
    chk("drain_done", drain_done, 1);
    chk("done_l0_ready", l0_ready, 0);
    chk("done_l1_ready", l1_ready, 0);
    step();
    chk("done_stays", drain_done, 1);
    chk("done_no_force", force_w, 0);
    drain_req = 1'b0;
    step();
    chk("back_run_done", drain_done, 0);
    chk("back_run_l0", l0_ready, 1);
    chk("back_run_l1", l1_ready, 1);
    hold = 1'b1;
    lane0(1, 30, 1, 1, 2);
    lane1(1, 31, 1, 1, 2);
    step();
    step();
    lane1(0, 0, 0, 0, 0);
    step();
    lane0(0, 0, 0, 0, 0);
    chk("rstmid_count5", fifo_count, 5);
    hold = 1'b0;
    step();
    chk("rstmid_issue", token_valid, 1);
    chk("rstmid_count4", fifo_count, 4);
    rst = 1'b1;
    step();
    chk("rstmid_count", fifo_count, 0);
    chk("rstmid_tv", token_valid, 0);
    chk("rstmid_force", force_w, 0);
    chk("rstmid_tid", token_buffer, 0);
    rst = 1'b0;
    step();
    chk("rstmid_after_tv", token_valid, 0);
    chk("rstmid_after_count", fifo_count, 0);
    chk("rstmid_run_done", drain_done, 0);
    chk("rstmid_run_l1", l1_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cvu_token_collector.md
Name: cvu_token_collector

Overview:
- Upstream feeder of the CVU/CVT stage.
- Collects per-thread branch-resolution results from two execution lanes and converts each into a token {thread ID, primary target BB, alternate target BB}.
- Buffers tokens in a 2-write/1-read FIFO and issues at most one token per cycle on token_valid/token_buffer/BB_target_1/BB_target_2.
- At kernel end it drains the FIFO, then pulses force_w so the CVU flushes its partial batch.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- TID_W, 10: CUDA thread ID width.
- BB_W, 5: basic-block index width.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- l0_valid  in  1  lane 0 result valid
- l0_tid  in  TID_W  lane 0 thread ID
- l0_taken  in  1  lane 0 branch outcome
- l0_bb_taken  in  BB_W  lane 0 taken-target BB
- l0_bb_fall  in  BB_W  lane 0 fall-through BB
- l0_ready  out  1  lane 0 may push
- l1_valid, l1_tid, l1_taken, l1_bb_taken, l1_bb_fall  in  1/TID_W/1/BB_W/BB_W  lane 1, same meaning as lane 0
- l1_ready  out  1  lane 1 may push
- hold  in  1  CVU busy; suppresses token issue
- drain_req  in  1  kernel finished; level signal
- token_valid  out  1  token presented this cycle
- token_buffer  out  TID_W  token thread ID
- BB_target_1  out  BB_W  primary target (the BB the thread goes to)
- BB_target_2  out  BB_W  alternate target (the other branch target)
- force_w  out  1  one-cycle pulse forcing a CVT write
- drain_done  out  1  drain complete
- fifo_count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Token formation: primary = taken ? bb_taken : bb_fall; alternate = the other target. Entry = {tid, primary, alternate}.
- Ready signals:
  - Decoded from registered count only; independent of valid and of same-cycle pop.
  - l0_ready = (count <= DEPTH-1) && state != DONE.
  - l1_ready = (count <= DEPTH-2) && state != DONE.
- Push: a lane pushes when valid && ready.
  - Both pushing: lane 0 is written first, then lane 1 (FIFO order l0, l1).
  - There is no write-through bypass.
- Issue:
  - Each cycle, if !hold && count != 0, register the head into the token outputs, set token_valid=1 and pop.
  - Otherwise token_valid=0; token data holds its last value.
  - Exactly one pop per issuing cycle.
- Latency: push accepted at edge k; earliest token_valid is after edge k+1.
- Count: count_next = count + pushes - pop. Pointers wrap modulo DEPTH.
- Full with a pop in the same cycle: push is still refused, because ready is decoded from the registered count.
- Empty with a push in the same cycle: no issue that cycle.
- FSM states: RUN, DRAIN, FORCE, DONE.
  - RUN: drain_req=1 -> DRAIN.
  - DRAIN: lanes are still accepted. Go to FORCE when count==0 && !hold && no push this cycle.
  - FORCE: force_w=1 for exactly one cycle -> DONE.
  - DONE: drain_done=1, both readies 0. drain_req=0 -> RUN.
  - drain_req is ignored in FORCE, and in DONE except for deassertion.
- Reset values: token_valid=0, token_buffer=0, BB_target_1=0, BB_target_2=0, force_w=0, drain_done=0, fifo_count=0, pointers=0, state=RUN.
- Reset mid-operation: all FIFO contents are discarded; no token or force_w is emitted in the reset cycle.

Optional Feature:
- Macro: CVU_TOKEN_STATS_EN.
- With the macro:
  - Adds output tok_issued [15:0]: saturating count of issued tokens.
  - Adds output hold_stall [15:0]: saturating count of cycles with hold && count != 0.
  - Both clear on rst and on the DONE->RUN transition.
- Without the macro: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cvu_token_pkg holds:
  - TID_W and BB_W constants.
  - typedef token_entry_t {tid, bb_primary, bb_alt}.
  - typedef enum collector_state_t {RUN, DRAIN, FORCE, DONE}.
- Sub-module token_fifo_2w1r: parameterised storage, pointers and count, with two ordered write ports and one read port.
- The FSM, token formation and output registers stay in the top module.

Test Plan:
- Single push, l0: tid=0x041, taken=1, bb_taken=7, bb_fall=3, hold=0 -> token_valid high 2 cycles after the push cycle with token_buffer=0x041, BB_target_1=7, BB_target_2=3.
- Dual push, same cycle, l0 tid=5 and l1 tid=6 -> tokens issue in consecutive cycles, 5 then 6; fifo_count goes 0,2,1,0.
- Fill: push until count=15 -> l1_ready=0 and l0_ready=1. At count=16 both readies are 0; a pop at full with l0_valid=1 is refused, and count goes to 15.
- Hold: 3 entries queued, hold=1 for 4 cycles -> token_valid=0 throughout; on release, 3 back-to-back tokens in FIFO order.
- Drain: 2 entries queued, drain_req=1 -> 2 tokens issue, then force_w=1 for one cycle, then drain_done=1. Dropping drain_req returns to RUN with readies at 1.
- Reset: rst asserted with 5 entries queued mid-issue -> next cycle fifo_count=0, token_valid=0, force_w=0, state RUN.
